// File: rtl/exp_series_engine.sv
// Sequential Taylor-series evaluator for e^x in signed Q8.8, fed by an external 1/(k+1) coefficient ROM.
// Define EXP_SAT_EN to make every narrowing saturate instead of wrapping.
module exp_series_engine #(
  parameter int N_TERMS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] x,
  output logic [3:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_X = 2'd1,
    MUL_C = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_K = 4'(N_TERMS - 1);

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [15:0] term_q, term_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] p_q, p_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic signed [31:0] mul_x_s;
  logic signed [31:0] mul_c_s;
  logic signed [31:0] sum_s;
  logic [15:0]        term_new_s;

  function automatic logic [15:0] sat16(input logic signed [31:0] v);
`ifdef EXP_SAT_EN
    if (v > 32'sd32767) begin
      sat16 = 16'h7FFF;
    end else if (v < -32'sd32768) begin
      sat16 = 16'h8000;
    end else begin
      sat16 = v[15:0];
    end
`else
    sat16 = v[15:0];
`endif
  endfunction

  // The coefficient is zero-extended so the ROM value is always treated as positive.
  assign mul_x_s    = $signed({{16{term_q[15]}}, term_q}) * $signed({{16{x_q[15]}}, x_q});
  assign mul_c_s    = $signed({{16{p_q[15]}}, p_q}) * $signed({16'h0000, rom_data});
  assign term_new_s = sat16(mul_c_s >>> 8);
  assign sum_s      = $signed({{16{acc_q[15]}}, acc_q}) + $signed({{16{term_new_s[15]}}, term_new_s});

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    term_d   = term_q;
    acc_d    = acc_q;
    p_d      = p_q;
    k_d      = k_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x;
          term_d  = 16'h0100;
          acc_d   = 16'h0100;
          k_d     = 4'd0;
          state_d = MUL_X;
        end else begin
          state_d = IDLE;
        end
      end
      MUL_X: begin
        p_d     = sat16(mul_x_s >>> 8);
        state_d = MUL_C;
      end
      MUL_C: begin
        term_d = term_new_s;
        acc_d  = sat16(sum_s);
        k_d    = k_q + 4'd1;
        if (k_q == LAST_K) begin
          state_d = DONE;
        end else begin
          state_d = MUL_X;
        end
      end
      DONE: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // busy covers the registered done cycle, which is spent back in IDLE.
    busy_d = (state_d != IDLE) || (state_q == DONE);
    if ((state_d == MUL_X) || (state_d == MUL_C)) begin
      addr_d = k_d;
    end else begin
      addr_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= 16'h0000;
      term_q   <= 16'h0000;
      acc_q    <= 16'h0000;
      p_q      <= 16'h0000;
      result_q <= 16'h0000;
      k_q      <= 4'd0;
      addr_q   <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      term_q   <= term_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      result_q <= result_d;
      k_q      <= k_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rom_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: tb/tb_exp_series_engine.sv
// Scoreboard bench for exp_series_engine: randomized operands against a plain-arithmetic series model.
module tb_exp_series_engine;
  localparam int N = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] x = 16'h0000;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy;
  logic        done;
  logic [15:0] result;

  exp_series_engine #(.N_TERMS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          acc_e;
    int          done_e;
    logic [15:0] res;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] held = 16'h0000;
  bit          chk_en = 1'b0;
  int          free_edge = 0;

  // Coefficient ROM: floor(256/(k+1)) in unsigned Q8.8.
  function automatic int coef(input int k);
    if (k < 12) return 256 / (k + 1);
    else return 0;
  endfunction

  always_comb rom_data = 16'(coef(int'(rom_addr)));

  function automatic longint floor256(input longint v);
    if (v >= 0) return v / 256;
    else return -((-v + 255) / 256);
  endfunction

  function automatic longint narrow(input longint v);
    longint w;
`ifdef EXP_SAT_EN
    if (v > 32767) w = 32767;
    else if (v < -32768) w = -32768;
    else w = v;
`else
    w = v & 64'h0000_0000_0000_FFFF;
    if (w >= 32768) w = w - 65536;
`endif
    return w;
  endfunction

  function automatic logic [15:0] model(input logic [15:0] xv);
    longint xs, term, acc, p;
    xs   = longint'($signed(xv));
    term = 256;
    acc  = 256;
    for (int k = 0; k < N; k++) begin
      p    = narrow(floor256(term * xs));
      term = narrow(floor256(p * longint'(coef(k))));
      acc  = narrow(acc + term);
    end
    return 16'(acc);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: derives per-cycle expectations from the scoreboard head.
  always @(posedge clk) begin
    int j;
    bit exp_busy, exp_done, rom_chk;
    int exp_rom;
    #1;
    if (chk_en) begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
      rom_chk  = 1'b1;
      exp_rom  = 0;
      if (sb.size() > 0 && cyc >= sb[0].acc_e && cyc <= sb[0].done_e) begin
        exp_busy = 1'b1;
        j = cyc - sb[0].acc_e;
        if (j < 2 * N) exp_rom = j / 2;
        else if (j == 2 * N) rom_chk = 1'b0;
        exp_done = (cyc == sb[0].done_e);
      end
      check("busy", int'(busy), int'(exp_busy));
      check("done", int'(done), int'(exp_done));
      if (rom_chk) check("rom_addr", int'(rom_addr), exp_rom);
      if (exp_done) held = sb[0].res;
      check("result", int'(result), int'(held));
      if (exp_done) void'(sb.pop_front());
    end
  end

  task automatic issue(input logic [15:0] xv, input logic [15:0] res);
    do @(negedge clk); while (cyc + 1 < free_edge);
    start = 1'b1;
    x     = xv;
    sb.push_back('{cyc + 1, cyc + 2 * N + 2, res});
    free_edge = cyc + 2 * N + 3;
  endtask

  task automatic run_op(input logic [15:0] xv, input logic [15:0] res, input bit noise);
    int a;
    issue(xv, res);
    a = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    x     = 16'($urandom);
    if (noise) begin
      while (cyc + 1 < free_edge) begin
        if (cyc + 1 == free_edge - 1 || cyc + 1 == a + 3) start = 1'b1;
        else start = 1'($urandom_range(0, 1));
        x = 16'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] xv;
    int a;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    free_edge = cyc + 1;

    run_op(16'h0000, 16'h0100, 1'b0);
    run_op(16'h0100, 16'h02B5, 1'b1);
    run_op(16'hFF00, 16'h005D, 1'b1);
`ifdef EXP_SAT_EN
    run_op(16'h0800, 16'h7FFF, 1'b1);
`else
    run_op(16'h0800, model(16'h0800), 1'b1);
`endif
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) xv = 16'($urandom);
      else xv = 16'($signed(16'($urandom_range(0, 1279))) - 16'sd640);
      run_op(xv, model(xv), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 3; i++) begin
      xv = 16'($urandom_range(0, 767));
      issue(xv, model(xv));
    end
    @(negedge clk);
    start = 1'b0;

    issue(16'h0100, 16'h02B5);
    a = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc + 1 < a + 7) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    held = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    free_edge = cyc + 1;
    run_op(16'hFF00, 16'h005D, 1'b0);

    while (cyc < free_edge + 2) @(negedge clk);
    check("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: got no completion, required finish before %0d cycles", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule
